// File: rtl/dut_drive_check.sv
// Vector driver/checker: pops drive+check pairs, drives the DUT, waits,
// samples the response under mask and posts a result word.
module dut_drive_check #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        clear,
  input  logic [23:0] sfifo_q,
  input  logic        sfifo_rdempty,
  output logic        sfifo_rdreq,
  input  logic [51:0] cfifo_q,
  input  logic        cfifo_rdempty,
  output logic        cfifo_rdreq,
  output logic [23:0] dut_out,
  output logic        dut_oe,
  input  logic [23:0] dut_in,
  output logic [39:0] rfifo_data,
  output logic        rfifo_wrreq,
  input  logic        rfifo_wrfull,
  output logic        busy,
  output logic [15:0] vec_count,
  output logic [15:0] fail_count
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SETTLE,
    SAMPLE,
    WRITE
  } state_t;

  localparam logic [8:0] SETTLE_W = 9'(SETTLE_CYCLES);

  state_t      state;
  state_t      state_nxt;
  logic [8:0]  cnt;
  logic [23:0] mask_r;
  logic [23:0] exp_r;
  logic [23:0] actual;
  logic        fail_r;
  logic [14:0] idx;
  logic        pop;
  logic        wr_fire;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    wr_fire   = 1'b0;
    unique case (state)
      IDLE: begin
        if (run) state_nxt = FETCH;
      end
      FETCH: begin
        if (!run) begin
          state_nxt = IDLE;
        end else if (!sfifo_rdempty && !cfifo_rdempty) begin
          pop       = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt <= 9'd1) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        state_nxt = WRITE;
      end
      WRITE: begin
        if (!rfifo_wrfull) begin
          wr_fire   = 1'b1;
          state_nxt = run ? FETCH : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sfifo_rdreq = pop;
  assign cfifo_rdreq = pop;
  assign rfifo_wrreq = wr_fire;
  assign busy        = (state != IDLE);
  assign rfifo_data  = {fail_r, idx, actual};

  always_ff @(posedge clock) begin
    if (reset) begin
      dut_out <= '0;
      dut_oe  <= 1'b0;
      mask_r  <= '0;
      exp_r   <= '0;
      cnt     <= '0;
      actual  <= '0;
      fail_r  <= 1'b0;
    end else begin
      if (pop) begin
        dut_out <= sfifo_q;
        dut_oe  <= 1'b1;
        mask_r  <= cfifo_q[47:24];
        exp_r   <= cfifo_q[23:0];
        cnt     <= SETTLE_W + {5'd0, cfifo_q[51:48]};
      end
      if (state == SETTLE) cnt <= cnt - 9'd1;
      if (state == SAMPLE) begin
        actual <= dut_in;
        fail_r <= |((dut_in ^ exp_r) & mask_r);
      end
    end
  end

  // clear beats a concurrent WRITE update
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      idx        <= '0;
      vec_count  <= '0;
      fail_count <= '0;
    end else if (wr_fire) begin
      idx <= idx + 15'd1;
      if (vec_count != 16'hFFFF) vec_count <= vec_count + 16'd1;
      if (fail_r && fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
    end
  end

endmodule

// File: doc/dut_drive_check.md
# dut_drive_check

Downstream consumer of the stimulus generator. Pops one 24-bit drive vector from the stimulus FIFO and one 52-bit check entry from the check FIFO, registers the vector onto the DUT pins, and waits a programmable settle time. It then samples the DUT response, compares it under mask against the expected value and pushes a 40-bit result word into the result FIFO. It also keeps vector and failure counters for the host.

## Interface
Parameters:
- SETTLE_CYCLES, 2: base wait (cycles) between driving a vector and sampling; legal 1..255.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; enables fetching of new vectors.
- clear  in  1  single-cycle pulse; zeroes vec_count, fail_count and the vector index.
- sfifo_q  in  24  stimulus FIFO head (show-ahead: valid whenever sfifo_rdempty=0).
- sfifo_rdempty  in  1  stimulus FIFO empty.
- sfifo_rdreq  out  1  pop stimulus FIFO.
- cfifo_q  in  52  check FIFO head, show-ahead; {wait[3:0], mask[23:0], expected[23:0]} = [51:48],[47:24],[23:0].
- cfifo_rdempty  in  1  check FIFO empty.
- cfifo_rdreq  out  1  pop check FIFO.
- dut_out  out  24  registered drive vector to DUT.
- dut_oe  out  1  DUT pin drivers enabled.
- dut_in  in  24  DUT response, already synchronised upstream of this block.
- rfifo_data  out  40  {fail, idx[14:0], actual[23:0]} = [39],[38:24],[23:0].
- rfifo_wrreq  out  1  push result.
- rfifo_wrfull  in  1  result FIFO full.
- busy  out  1  high in any state other than IDLE.
- vec_count  out  16  vectors completed, saturates at 16'hFFFF.
- fail_count  out  16  failing vectors, saturates at 16'hFFFF.

## Operation
- States: IDLE, FETCH, SETTLE, SAMPLE, WRITE.
- IDLE:
  - If run=1, go to FETCH.
  - dut_oe holds its last value; 0 after reset.
- FETCH:
  - When sfifo_rdempty=0 and cfifo_rdempty=0, assert sfifo_rdreq and cfifo_rdreq together for exactly one cycle.
  - Register sfifo_q into dut_out. Set dut_oe=1.
  - Latch mask, expected and wait. Load the settle counter with SETTLE_CYCLES + wait (9-bit add, no overflow possible). Go to SETTLE.
  - If only one FIFO is non-empty, pop neither and stay.
  - If run=0, return to IDLE.
- SETTLE: decrement the counter each cycle; when it reaches 1, go to SAMPLE.
- SAMPLE:
  - Register dut_in into actual.
  - fail = |((actual ^ expected) & mask). mask=0 means the vector always passes.
  - Go to WRITE.
- WRITE:
  - If rfifo_wrfull=0: assert rfifo_wrreq for one cycle with {fail, idx, actual}.
  - Increment idx (15-bit, wraps 7FFF→0000) and vec_count. Increment fail_count if fail.
  - Then go to FETCH if run=1, else IDLE.
  - If rfifo_wrfull=1: hold state and data, assert nothing, and retry every cycle.
- run deasserted mid-vector: the current vector completes through WRITE, then the FSM goes to IDLE. A vector is never half-consumed.
- clear:
  - Takes effect in any state.
  - If clear and a WRITE increment happen in the same cycle, clear wins and the counters read 0.
  - Does not alter the FSM or the DUT pins.
- reset:
  - Acts from any state, including mid-vector; the in-flight vector is discarded.
  - Reset values: state=IDLE, dut_out=0, dut_oe=0, sfifo_rdreq=0, cfifo_rdreq=0, rfifo_wrreq=0, rfifo_data=0, busy=0, vec_count=0, fail_count=0, idx=0.

## Timing
- Pop at edge N: dut_out is valid from N+1.
- actual is captured at edge N+1+W, where W = SETTLE_CYCLES + wait.
- rfifo_wrreq is high in the cycle after sampling, given rfifo not full.
- Minimum per-vector period is W+3 cycles (FETCH, W settle cycles, SAMPLE, WRITE), back-to-back with run=1.
- rdreq signals are combinational on state and empty flags. They are never asserted when the matching empty flag is 1.
- rfifo_wrreq is never asserted while rfifo_wrfull=1.
- At most one result is written per popped vector pair.
- dut_out changes only on the FETCH pop edge.

## Test plan
- Single pass:
  - Stimulus: SETTLE_CYCLES=2; sfifo=24'hA5A5A5; cfifo={4'h0, 24'hFFFFFF, 24'hA5A5A5}; dut_in loops dut_out back.
  - Response: one result 40'h00_00A5A5A5 (fail=0, idx=0); vec_count=1; fail_count=0; rfifo_wrreq exactly 4 cycles after the pop.
- Masked mismatch:
  - Stimulus: expected 24'h000001, dut_in=24'h000003.
  - Response: mask 24'h000001 gives fail=0; mask 24'h000002 gives fail=1, and fail_count increments.
- Wait field: cfifo wait=4'hF with SETTLE_CYCLES=2 -> sample 17 cycles after dut_out changes; changing dut_in one cycle earlier has no effect on actual.
- Backpressure:
  - Stimulus: rfifo_wrfull=1 for 10 cycles during WRITE, with both input FIFOs still holding data.
  - Response: no wrreq and no further pops during the stall; the result is written the cycle wrfull falls, with unchanged data.
- Imbalance/stop:
  - Stimulus: cfifo empty while sfifo holds data; then run is dropped mid-SETTLE.
  - Response: no pops while cfifo is empty; the in-flight vector still writes its result; busy falls the cycle after WRITE.
- Reset and clear:
  - Stimulus: reset asserted during SETTLE; separately, clear pulsed in the same cycle as a failing WRITE.
  - Response: all outputs at reset values on the next edge; counters read 0 after the clear/WRITE collision; idx wraps 7FFF→0 after 32768 vectors.
